// File: rtl/i2c_slave_responder_if.sv
// Local-side interface of the I2C responder: received-byte delivery,
// transmit-byte request handshake and status flags.
interface i2c_slave_responder_if;
    logic [7:0] tx_data_in;
    logic [7:0] rx_data_out;
    logic       rx_valid;
    logic       tx_req;
    logic       addr_hit;
    logic       busy;

    // The responder drives the status/receive side and consumes tx_data_in.
    modport slave (
        input  tx_data_in,
        output rx_data_out, rx_valid, tx_req, addr_hit, busy
    );

    // Local register/FIFO logic sits on this side.
    modport master (
        output tx_data_in,
        input  rx_data_out, rx_valid, tx_req, addr_hit, busy
    );
endinterface

// File: rtl/i2c_slave_responder.sv
// I2C target endpoint. Oversamples SCL/SDA on the local clock, detects
// START/STOP, matches a 7-bit address, ACKs written bytes and serves read
// bytes through a one-cycle tx_req handshake.
// Optional build macro: I2C_SLAVE_GENERAL_CALL_EN also answers the general
// call write address byte 8'h00.
// The pad pins stay on plain ports so the open-drain resolution of SDA is
// local to this module; the register-side handshake uses the interface.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                        i2c_clock_in,
    input  logic                        i2c_reset_in,
    input  logic                        i2c_scl,
    inout  wire                         i2c_sda,
    i2c_slave_responder_if.slave        bus
);

`ifdef I2C_SLAVE_GENERAL_CALL_EN
    localparam bit GENERAL_CALL = 1'b1;
`else
    localparam bit GENERAL_CALL = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_AACK,
        ST_WRITE,
        ST_WACK,
        ST_READ,
        ST_RACK,
        ST_IGNORE
    } state_t;

    // Synchroniser chains and the previous synchronised sample
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;

    // Protocol state
    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       rw_q, rw_d;
    logic       sda_low_q, sda_low_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req;

    logic       scl_now, sda_now;
    logic       scl_rise, scl_fall;
    logic       start_det, stop_det;
    logic [7:0] byte_in;
    logic       addr_match;

    // Bring the asynchronous bus lines into the local clock domain
    always_ff @(posedge i2c_clock_in or posedge i2c_reset_in) begin
        // NOTE: the synchronisers reset to the idle bus level (1) so that
        // leaving reset never looks like an SDA fall with SCL high (START).
        if (i2c_reset_in) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the value
            // from before the edge, which is what forms a shift chain.
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_now   = scl_sync[SYNC_STAGES-1];
    assign sda_now   = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_now & ~scl_prev;
    assign scl_fall  = ~scl_now & scl_prev;
    assign start_det = scl_now & scl_prev & sda_prev & ~sda_now;
    assign stop_det  = scl_now & scl_prev & ~sda_prev & sda_now;
    assign byte_in   = {shift_q[6:0], sda_now};
    assign addr_match = (byte_in[7:1] == SLAVE_ADDR) ||
                        (GENERAL_CALL && (byte_in == 8'h00));

    // State and datapath registers
    always_ff @(posedge i2c_clock_in or posedge i2c_reset_in) begin
        if (i2c_reset_in) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            tx_shift_q <= 8'h00;
            rw_q       <= 1'b0;
            sda_low_q  <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_shift_q <= tx_shift_d;
            rw_q       <= rw_d;
            sda_low_q  <= sda_low_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // Next-state, bit handling and the tx_req strobe
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_shift_d = tx_shift_q;
        rw_d       = rw_q;
        sda_low_d  = sda_low_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req     = 1'b0;

        if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            sda_low_d = 1'b0;
        end else if (start_det) begin
            // Covers both a fresh START and a repeated START in any state
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_low_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    sda_low_d = 1'b0;
                end

                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            rw_d    = byte_in[0];
                            state_d = addr_match ? ST_AACK : ST_IGNORE;
                        end
                    end
                end

                ST_AACK: begin
                    if (scl_rise) begin
                        bit_cnt_d = 4'd9;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_low_d = 1'b1;
                    end else if (scl_fall && bit_cnt_q == 4'd9) begin
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            // First read byte goes out on the fall ending the ACK
                            tx_req     = 1'b1;
                            tx_shift_d = bus.tx_data_in;
                            sda_low_d  = ~bus.tx_data_in[7];
                            state_d    = ST_READ;
                        end else begin
                            sda_low_d = 1'b0;
                            state_d   = ST_WRITE;
                        end
                    end
                end

                ST_WRITE: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                            state_d    = ST_WACK;
                        end
                    end
                end

                ST_WACK: begin
                    if (scl_rise) begin
                        bit_cnt_d = 4'd9;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_low_d = 1'b1;
                    end else if (scl_fall && bit_cnt_q == 4'd9) begin
                        sda_low_d = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = ST_WRITE;
                    end
                end

                ST_READ: begin
                    if (scl_rise) begin
                        if (!sda_low_q && !sda_now) begin
                            // Released for a 1 but the line is low: lost the bus
                            sda_low_d = 1'b0;
                            state_d   = ST_IGNORE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_low_d = 1'b0;
                            state_d   = ST_RACK;
                        end else begin
                            sda_low_d  = ~tx_shift_q[6];
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        end
                    end
                end

                ST_RACK: begin
                    if (scl_rise) begin
                        if (sda_now) begin
                            state_d = ST_IGNORE;
                        end else begin
                            bit_cnt_d = 4'd9;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd9) begin
                        tx_req     = 1'b1;
                        tx_shift_d = bus.tx_data_in;
                        sda_low_d  = ~bus.tx_data_in[7];
                        bit_cnt_d  = 4'd0;
                        state_d    = ST_READ;
                    end
                end

                ST_IGNORE: begin
                    sda_low_d = 1'b0;
                end

                default: begin
                    sda_low_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            endcase
        end
    end

    // Open-drain pad: pull low or release, never drive high
    assign i2c_sda = sda_low_q ? 1'b0 : 1'bz;

    assign bus.rx_data_out = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_req      = tx_req;
    assign bus.addr_hit    = state_q inside {ST_AACK, ST_WRITE, ST_WACK, ST_READ, ST_RACK};
    assign bus.busy        = (state_q != ST_IDLE);

endmodule
